// File: rtl/wsi_sink_signature.sv
// WSI write sink that folds accepted beats into a 32-bit MISR signature,
// counts beats and bursts, checks precise burst lengths and applies a
// registered post-burst backpressure window.
module wsi_sink_signature #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] SEED        = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   wsiS_MCmd,
    input  logic         wsiS_MReqLast,
    input  logic         wsiS_MBurstPrecise,
    input  logic [11:0]  wsiS_MBurstLength,
    input  logic [255:0] wsiS_MData,
    input  logic [31:0]  wsiS_MByteEn,
    input  logic         wsiS_MReset_n,
    output logic         wsiS_SThreadBusy,
    output logic         wsiS_SReset_n,
    output logic [31:0]  signature,
    output logic [15:0]  word_count,
    output logic [15:0]  burst_count,
    output logic         sig_valid,
    output logic [1:0]   status
);

    localparam logic [2:0]  CmdWrite = 3'b001;
    localparam logic [3:0]  HoldLast = 4'(HOLD_CYCLES - 1);
    localparam logic [11:0] BeatMax  = 12'hFFF;

    typedef enum logic [1:0] {StIdle, StBurst, StHold} state_e;

    state_e       state_q, state_d;
    logic [3:0]   hold_cnt_q, hold_cnt_d;
    logic         busy_q, busy_d;
    logic         sreset_n_q;
    logic [31:0]  sig_q, sig_d;
    logic [15:0]  word_cnt_q, burst_cnt_q;
    logic         sig_valid_q;
    logic         len_err_q, overrun_q;
    logic [11:0]  beat_cnt_q;
    logic         precise_q;
    logic [11:0]  len_q;

    logic         is_write, accept, drop, last_accept;
    logic         first_beat, eff_precise, len_mismatch;
    logic [11:0]  eff_len, beats_incl;
    logic [255:0] masked;
    logic [31:0]  fold;

    assign is_write    = (wsiS_MCmd == CmdWrite);
    assign accept      = is_write && wsiS_MReset_n && !busy_q;
    assign drop        = is_write && busy_q;
    assign last_accept = accept && wsiS_MReqLast;

    // Mask disabled bytes, then XOR the eight 32-bit lanes together.
    always_comb begin
        masked = '0;
        for (int i = 0; i < 32; i++) begin
            masked[8*i +: 8] = wsiS_MData[8*i +: 8] & {8{wsiS_MByteEn[i]}};
        end
        fold = '0;
        for (int j = 0; j < 8; j++) begin
            fold = fold ^ masked[32*j +: 32];
        end
    end

    // MISR step applied only to accepted beats.
    always_comb begin
        sig_d = sig_q;
        if (accept) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold;
        end
    end

    // FSM state register plus hold-window counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // FSM next state; upstream reset forces IDLE from any state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (!wsiS_MReset_n) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d    = wsiS_MReqLast ? StHold : StBurst;
                        hold_cnt_d = HoldLast;
                    end
                end
                StBurst: begin
                    if (last_accept) begin
                        state_d    = StHold;
                        hold_cnt_d = HoldLast;
                    end
                end
                StHold: begin
                    if (hold_cnt_q == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 4'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM-decoded burst bookkeeping: a beat seen in IDLE opens a burst and
    // its own precise/length fields apply directly.
    always_comb begin
        first_beat   = accept && (state_q == StIdle);
        eff_precise  = first_beat ? wsiS_MBurstPrecise : precise_q;
        eff_len      = first_beat ? wsiS_MBurstLength : len_q;
        beats_incl   = first_beat ? 12'd1 :
                       ((beat_cnt_q == BeatMax) ? BeatMax : beat_cnt_q + 12'd1);
        len_mismatch = last_accept && eff_precise && (beats_incl != eff_len);
        busy_d       = (state_d == StHold) || !wsiS_MReset_n || !sreset_n_q;
    end

    // Handshake registers: sink-ready rises one edge after reset, busy one later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreset_n_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            sreset_n_q <= 1'b1;
            busy_q     <= busy_d;
        end
    end

    // Signature, counters, sticky flags and per-burst capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q       <= SEED;
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
            sig_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            beat_cnt_q  <= '0;
            precise_q   <= 1'b0;
            len_q       <= '0;
        end else begin
            sig_q       <= sig_d;
            sig_valid_q <= last_accept;
            if (accept) begin
                word_cnt_q <= word_cnt_q + 16'd1;
                beat_cnt_q <= beats_incl;
            end
            if (first_beat) begin
                precise_q <= wsiS_MBurstPrecise;
                len_q     <= wsiS_MBurstLength;
            end
            if (last_accept) begin
                burst_cnt_q <= burst_cnt_q + 16'd1;
            end
            if (len_mismatch) begin
                len_err_q <= 1'b1;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign wsiS_SThreadBusy = busy_q;
    assign wsiS_SReset_n    = sreset_n_q;
    assign signature        = sig_q;
    assign word_count       = word_cnt_q;
    assign burst_count      = burst_cnt_q;
    assign sig_valid        = sig_valid_q;
    assign status           = {overrun_q, len_err_q};

endmodule

// File: tb/tb_wsi_sink_signature.sv
// Randomised bench for wsi_sink_signature against a transaction-level model.
module tb_wsi_sink_signature;

    localparam int unsigned Hold = 2;
    localparam logic [31:0] Poly = 32'h04C11DB7;
    localparam logic [31:0] Seed = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   mcmd;
    logic         mreqlast;
    logic         mprecise;
    logic [11:0]  mlen;
    logic [255:0] mdata;
    logic [31:0]  mbyteen;
    logic         mreset_n;
    logic         sthreadbusy;
    logic         sreset_n;
    logic [31:0]  signature;
    logic [15:0]  word_count;
    logic [15:0]  burst_count;
    logic         sig_valid;
    logic [1:0]   status;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] exp_sig;
    logic [15:0] exp_wc, exp_bc;
    logic        exp_err, exp_ovr;
    bit          in_burst;
    bit          cap_p;
    int          cap_l, nb;

    wsi_sink_signature #(.HOLD_CYCLES(Hold), .POLY(Poly), .SEED(Seed)) dut (
        .clk                (clk),
        .reset              (reset),
        .wsiS_MCmd          (mcmd),
        .wsiS_MReqLast      (mreqlast),
        .wsiS_MBurstPrecise (mprecise),
        .wsiS_MBurstLength  (mlen),
        .wsiS_MData         (mdata),
        .wsiS_MByteEn       (mbyteen),
        .wsiS_MReset_n      (mreset_n),
        .wsiS_SThreadBusy   (sthreadbusy),
        .wsiS_SReset_n      (sreset_n),
        .signature          (signature),
        .word_count         (word_count),
        .burst_count        (burst_count),
        .sig_valid          (sig_valid),
        .status             (status)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-wise fold: each enabled byte lands at its position within a 32-bit word.
    function automatic logic [31:0] ref_fold(input logic [255:0] d, input logic [31:0] be);
        logic [31:0] acc = 32'h0;
        logic [31:0] b;
        for (int k = 0; k < 32; k++) begin
            if (be[k]) begin
                b   = {24'h0, d[8*k +: 8]} << (8 * (k % 4));
                acc = acc ^ b;
            end
        end
        return acc;
    endfunction

    function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [31:0] f);
        logic [31:0] fb = s[31] ? Poly : 32'h0;
        return (s << 1) ^ fb ^ f;
    endfunction

    task automatic model_reset();
        exp_sig  = Seed;
        exp_wc   = '0;
        exp_bc   = '0;
        exp_err  = 1'b0;
        exp_ovr  = 1'b0;
        in_burst = 0;
        nb       = 0;
    endtask

    task automatic idle_inputs();
        mcmd     = 3'b000;
        mreqlast = 1'b0;
        mprecise = 1'b0;
        mlen     = '0;
        mdata    = '0;
        mbyteen  = '0;
    endtask

    // Entered and left on a negedge; resets the DUT and checks the release sequence.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("rst_sig", signature, Seed);
        check_eq("rst_wc", {16'h0, word_count}, 32'h0);
        check_eq("rst_bc", {16'h0, burst_count}, 32'h0);
        check_eq("rst_sigvalid", {31'h0, sig_valid}, 32'h0);
        check_eq("rst_status", {30'h0, status}, 32'h0);
        check_eq("rst_busy", {31'h0, sthreadbusy}, 32'h1);
        check_eq("rst_sreset", {31'h0, sreset_n}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rel_sreset", {31'h0, sreset_n}, 32'h1);
        check_eq("rel_busy_hi", {31'h0, sthreadbusy}, 32'h1);
        @(negedge clk);
        check_eq("rel_busy_lo", {31'h0, sthreadbusy}, 32'h0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (sthreadbusy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("ready_timeout", 32'h0, 32'h1);
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] be, input logic last,
                             input logic prec, input logic [11:0] len);
        wait_ready();
        mcmd     = 3'b001;
        mdata    = d;
        mbyteen  = be;
        mreqlast = last;
        mprecise = in_burst ? 1'($urandom) : prec;
        mlen     = in_burst ? 12'($urandom) : len;
        @(posedge clk);
        exp_sig = ref_misr(exp_sig, ref_fold(d, be));
        exp_wc++;
        if (!in_burst) begin
            in_burst = 1;
            cap_p    = prec;
            cap_l    = int'(len);
            nb       = 0;
        end
        if (nb < 4095) nb++;
        if (last) begin
            exp_bc++;
            if (cap_p && nb != cap_l) exp_err = 1'b1;
            in_burst = 0;
        end
        @(negedge clk);
        idle_inputs();
        check_eq("sig", signature, exp_sig);
        check_eq("wc", {16'h0, word_count}, {16'h0, exp_wc});
        check_eq("bc", {16'h0, burst_count}, {16'h0, exp_bc});
        check_eq("sig_valid", {31'h0, sig_valid}, {31'h0, last});
        check_eq("status", {30'h0, status}, {30'h0, exp_ovr, exp_err});
    endtask

    // Called at the negedge right after a last beat: measure the busy window.
    task automatic check_hold();
        int cnt = 0;
        while (sthreadbusy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
            if (cnt == 1) check_eq("sig_valid_width", {31'h0, sig_valid}, 32'h0);
        end
        check_eq("hold_len", cnt, Hold);
    endtask

    initial begin
        logic [255:0] ones = '1;
        logic [15:0]  bc_before, wc_before;
        idle_inputs();
        mreset_n = 1'b1;
        reset    = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single-beat burst of zero data
        send_beat('0, 32'hFFFF_FFFF, 1'b1, 1'b1, 12'd1);
        check_eq("single_sig_const", signature, 32'hFB3EE249);
        check_hold();
        check_eq("single_status", {30'h0, status}, 32'h0);

        // Masking: all-ones data fully disabled gives the same signature
        do_reset();
        send_beat(ones, 32'h0, 1'b1, 1'b1, 12'd1);
        check_eq("mask_sig_const", signature, 32'hFB3EE249);
        check_hold();

        // Precise length 4 ended after 3 beats
        do_reset();
        send_beat(256'($urandom), 32'($urandom), 1'b0, 1'b1, 12'd4);
        send_beat(256'($urandom), 32'($urandom), 1'b0, 1'b1, 12'd4);
        send_beat(256'($urandom), 32'($urandom), 1'b1, 1'b1, 12'd4);
        check_eq("lenerr_flag", {31'h0, status[0]}, 32'h1);
        check_eq("lenerr_wc", {16'h0, word_count}, 32'd3);
        send_beat(256'($urandom), 32'($urandom), 1'b0, 1'b1, 12'd2);
        send_beat(256'($urandom), 32'($urandom), 1'b1, 1'b1, 12'd2);
        check_eq("lenerr_sticky", {31'h0, status[0]}, 32'h1);

        // WRITE during HOLD is dropped and flags overrun
        send_beat(256'($urandom), 32'($urandom), 1'b1, 1'b0, 12'd0);
        wc_before = word_count;
        mcmd      = 3'b001;
        mreqlast  = 1'b1;
        mdata     = ones;
        mbyteen   = '1;
        @(negedge clk);
        idle_inputs();
        exp_ovr = 1'b1;
        check_eq("ovr_wc", {16'h0, word_count}, {16'h0, exp_wc});
        check_eq("ovr_wc_hold", {16'h0, word_count}, {16'h0, wc_before});
        check_eq("ovr_flag", {30'h0, status}, {30'h0, exp_ovr, exp_err});
        check_eq("ovr_sig", signature, exp_sig);

        // Upstream reset abandons a partial burst
        do_reset();
        send_beat(256'($urandom), 32'($urandom), 1'b0, 1'b1, 12'd4);
        send_beat(256'($urandom), 32'($urandom), 1'b0, 1'b1, 12'd4);
        bc_before = burst_count;
        mreset_n  = 1'b0;
        @(negedge clk);
        mreset_n = 1'b1;
        in_burst = 0;
        check_eq("mrst_sigvalid", {31'h0, sig_valid}, 32'h0);
        check_eq("mrst_busy", {31'h0, sthreadbusy}, 32'h1);
        check_eq("mrst_bc", {16'h0, burst_count}, {16'h0, bc_before});
        check_eq("mrst_wc", {16'h0, word_count}, 32'd2);
        check_eq("mrst_sig", signature, exp_sig);
        for (int b = 0; b < 4; b++) begin
            send_beat(256'($urandom), 32'($urandom), (b == 3), 1'b1, 12'd4);
        end
        check_eq("mrst_resume_status", {30'h0, status}, 32'h0);
        check_hold();

        // Asynchronous reset mid-burst
        send_beat(256'($urandom), 32'($urandom), 1'b0, 1'b1, 12'd3);
        do_reset();

        // Randomised bursts with idle gaps of ignored commands
        for (int n = 0; n < 40; n++) begin
            int beats = 1 + int'($urandom % 6);
            logic        prec = 1'($urandom);
            logic [11:0] len  = 12'(($urandom % 4 == 0) ? beats + 1 : beats);
            for (int b = 0; b < beats; b++) begin
                while ($urandom % 3 == 0) begin
                    logic [2:0] code = 3'($urandom);
                    if (code == 3'b001) code = 3'b000;
                    mcmd     = code;
                    mreqlast = 1'($urandom);
                    mdata    = {8{32'($urandom)}};
                    mbyteen  = 32'($urandom);
                    @(negedge clk);
                    idle_inputs();
                end
                send_beat({8{32'($urandom)}}, 32'($urandom), (b == beats - 1), prec, len);
            end
        end
        wait_ready();
        check_eq("rand_final_bc", {16'h0, burst_count}, {16'h0, exp_bc});
        check_eq("rand_final_status", {30'h0, status}, {30'h0, exp_ovr, exp_err});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
